// File: rtl/alu_seq16.sv
// 16-bit add/subtract sequencer that drives an external 8-bit ALU over two
// cycles (low byte, then high byte) and registers the result and flags.
module alu_seq16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_h,
  output logic        flag_c,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  output logic        alu_sub,
  input  logic [7:0]  alu_res,
  input  logic        alu_cout,
  input  logic        alu_hcout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_opa;
  logic [15:0] r_opb;
  logic [1:0]  r_op;
  logic        r_cin;
  logic        r_c_lo;
  logic [7:0]  r_res_lo;
  logic [15:0] r_result;
  logic        r_z;
  logic        r_n;
  logic        r_h;
  logic        r_c;
  logic        w_start;
  logic [15:0] w_full;

  assign w_start = (r_state == S_IDLE) && req;
  assign w_full  = {alu_res, r_res_lo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (req) w_next = S_LO;
      S_LO:   w_next = S_HI;
      S_HI:   w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_sub = 1'b0;
    unique case (r_state)
      S_LO: begin
        alu_a   = r_opa[7:0];
        alu_b   = r_opb[7:0];
        alu_sub = r_op[1];
        alu_cin = r_op[0] & r_cin;
      end
      S_HI: begin
        alu_a   = r_opa[15:8];
        alu_b   = r_opb[15:8];
        alu_sub = r_op[1];
        alu_cin = r_c_lo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_opa <= '0;
      r_opb <= '0;
      r_op  <= '0;
      r_cin <= 1'b0;
    end else if (w_start) begin
      r_opa <= opa;
      r_opb <= opb;
      r_op  <= op;
      r_cin <= cin;
    end
  end

  // Low byte is staged internally and committed with the high byte, so the
  // visible result stays stable from one completion to the next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c_lo   <= 1'b0;
      r_res_lo <= '0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_h      <= 1'b0;
      r_c      <= 1'b0;
    end else begin
      if (r_state == S_LO) begin
        r_res_lo <= alu_res;
        r_c_lo   <= alu_cout;
      end
      if (r_state == S_HI) begin
        r_result <= w_full;
        r_z      <= (w_full == '0);
        r_n      <= r_op[1];
        r_h      <= alu_hcout;
        r_c      <= alu_cout;
      end
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign flag_z = r_z;
  assign flag_n = r_n;
  assign flag_h = r_h;
  assign flag_c = r_c;

endmodule
